// File: rtl/pe_gather.sv
// pe_gather: captures one frame of DATA_DEPTH packed lane words in a single
// handshake, then streams the masked lanes out one word per beat, lowest index first.
// Latency: a capture at edge N gives the first beat in cycle N+1. Backpressure:
// the beat is held stable until out_ready. In the default build, cap_ready is low while streaming.
// Macro PE_GATHER_PIPE_EN: a new frame may be captured on the last-beat cycle,
//   giving zero-bubble frames. This adds a combinational path from out_ready to cap_ready.
// Ports: clk/rst (sync, active-high); cap_valid/cap_ready/cap_data/cap_mask frame
//   input; out_valid/out_ready/out_data/out_sel/out_last beat output; busy = streaming.
module pe_gather #(
  parameter int DATA_WIDTH = 8,
  parameter int DATA_DEPTH = 33,
  parameter int SEL_WIDTH  = $clog2(DATA_DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             cap_valid,
  output logic                             cap_ready,
  input  logic [DATA_DEPTH*DATA_WIDTH-1:0] cap_data,
  input  logic [DATA_DEPTH-1:0]            cap_mask,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [DATA_WIDTH-1:0]            out_data,
  output logic [SEL_WIDTH-1:0]             out_sel,
  output logic                             out_last,
  output logic                             busy
);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                           state_q, state_d;
  logic [DATA_DEPTH*DATA_WIDTH-1:0] data_q, data_d;
  logic [DATA_DEPTH-1:0]            pend_q, pend_d;
  logic [DATA_DEPTH-1:0]            pend_rest;
  logic [SEL_WIDTH-1:0]             sel;
  logic                             beat_acc;
  logic                             cap_acc;

  // Priority encoder. The loop scans from high to low, so the lowest set bit wins.
  // An empty pend_q yields index 0.
  always_comb begin
    sel = '0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
      if (pend_q[i]) sel = SEL_WIDTH'(i);
    end
  end

  // Clearing the lowest set bit leaves the bits still to be sent after this beat.
  // If nothing is left, this beat is the last one.
  assign pend_rest = pend_q & (pend_q - DATA_DEPTH'(1));

  assign out_valid = (state_q == STREAM);
  assign busy      = (state_q == STREAM);
  assign out_sel   = sel;
  assign out_data  = data_q[sel*DATA_WIDTH +: DATA_WIDTH];
  assign out_last  = (state_q == STREAM) && (pend_rest == '0);

`ifdef PE_GATHER_PIPE_EN
  assign cap_ready = (state_q == IDLE) || (out_valid && out_last && out_ready);
`else
  assign cap_ready = (state_q == IDLE);
`endif

  assign beat_acc = out_valid && out_ready;
  assign cap_acc  = cap_valid && cap_ready;

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    pend_d  = pend_q;
    if (beat_acc) begin
      pend_d = pend_rest;
      if (out_last) state_d = IDLE;
    end
    // A capture overrides the beat update. When both happen in one cycle, the
    // beat was the last of its frame, so the old pending mask is empty anyway.
    if (cap_acc) begin
      data_d  = cap_data;
      pend_d  = cap_mask;
      state_d = (cap_mask != '0) ? STREAM : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      pend_q  <= pend_d;
    end
  end

endmodule

// File: tb/tb_pe_gather.sv
module tb_pe_gather;
  localparam int DW = 8;
  localparam int DD = 33;
  localparam int SW = $clog2(DD);
`ifdef PE_GATHER_PIPE_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, cap_valid, cap_ready, out_valid, out_ready, out_last, busy;
  logic [DD*DW-1:0] cap_data;
  logic [DD-1:0] cap_mask;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_sel;

  pe_gather #(.DATA_WIDTH(DW), .DATA_DEPTH(DD), .SEL_WIDTH(SW)) dut (
    .clk(clk), .rst(rst), .cap_valid(cap_valid), .cap_ready(cap_ready),
    .cap_data(cap_data), .cap_mask(cap_mask), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .out_last(out_last), .busy(busy));

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [DW-1:0] data;
    logic          last;
  } beat_t;

  beat_t mq[$];     // model: beats still owed by the current frame
  beat_t logq[$];   // beats actually accepted from the DUT
  int    logcyc[$];
  int    cyc = 0;
  bit    live = 1'b0;
  bit    m_rdy = 1'b0;
  int    tests = 0;
  int    fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic bit m_ready();
    if (mq.size() == 0) return 1'b1;
    return PIPE && (mq.size() == 1) && out_ready;
  endfunction

  // Model update: consume the head beat on acceptance, then expand a newly captured frame into its beat list.
  always @(posedge clk) begin
    bit r;
    int hi;
    beat_t b;
    r = m_ready();
    if (rst) begin
      mq.delete();
      live = 1'b1;
    end else if (live) begin
      if (mq.size() != 0 && out_ready) void'(mq.pop_front());
      if (cap_valid && r) begin
        hi = -1;
        for (int i = 0; i < DD; i++) if (cap_mask[i]) hi = i;
        for (int i = 0; i < DD; i++) begin
          if (cap_mask[i]) begin
            b.sel  = SW'(i);
            b.data = cap_data[i*DW +: DW];
            b.last = (i == hi);
            mq.push_back(b);
          end
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    beat_t b;
    cyc++;
    if (live) begin
      m_rdy = m_ready();
      chk("out_valid", out_valid, mq.size() != 0);
      chk("busy", busy, mq.size() != 0);
      chk("cap_ready", cap_ready, m_rdy);
      if (mq.size() != 0) begin
        chk("out_sel", out_sel, mq[0].sel);
        chk("out_data", out_data, mq[0].data);
        chk("out_last", out_last, mq[0].last);
      end
      if (out_valid && out_ready) begin
        b.sel = out_sel; b.data = out_data; b.last = out_last;
        logq.push_back(b);
        logcyc.push_back(cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Call this just after a rising edge. It holds the frame until the model says it was captured.
  task automatic send(input logic [DD*DW-1:0] d, input logic [DD-1:0] m);
    bit done;
    done = 1'b0;
    cap_data = d; cap_mask = m; cap_valid = 1'b1;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk); #1;
      if (m_rdy) begin
        @(posedge clk); #1;
        done = 1'b1;
      end
    end
    cap_valid = 1'b0;
    if (!done) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (mq.size() != 0 && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    if (mq.size() != 0) chk("drain_timeout", 0, 1);
  endtask

  task automatic chk_full_log(input string nm);
    int nl;
    nl = 0;
    chk({nm, "_count"}, logq.size(), 33);
    for (int k = 0; k < logq.size() && k < 33; k++) begin
      chk({nm, "_sel"}, logq[k].sel, k);
      chk({nm, "_data"}, logq[k].data, k + 1);
      nl += int'(logq[k].last);
    end
    chk({nm, "_nlast"}, nl, 1);
    if (logq.size() == 33) chk({nm, "_last32"}, logq[32].last, 1);
  endtask

  logic [DD*DW-1:0] dfull, d;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cap_valid = 1'b0; cap_data = '0; cap_mask = '0; out_ready = 1'b1;
    for (int i = 0; i < DD; i++) dfull[i*DW +: DW] = DW'(i + 1);
    tick(); tick();
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cap_ready", cap_ready, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sel", out_sel, 0);
    chk("rst_out_last", out_last, 0);
    tick();

    // Full mask, lane i = i+1
    logq.delete(); logcyc.delete();
    send(dfull, {DD{1'b1}});
    drain();
    chk_full_log("full");
    chk("full_rdy_after", cap_ready, 1);
    if (logcyc.size() == 33) chk("full_consec", logcyc[32] - logcyc[0], 32);
    tick();

    // Sparse mask {0,2,32}
    d = {DD{8'h11}};
    d[0*DW +: DW] = 8'hA0; d[2*DW +: DW] = 8'hA2; d[32*DW +: DW] = 8'hC0;
    logq.delete(); logcyc.delete();
    send(d, 33'h1_0000_0005);
    drain();
    chk("sparse_count", logq.size(), 3);
    if (logq.size() == 3) begin
      chk("sparse_b0", logq[0], {6'd0, 8'hA0, 1'b0});
      chk("sparse_b1", logq[1], {6'd2, 8'hA2, 1'b0});
      chk("sparse_b2", logq[2], {6'd32, 8'hC0, 1'b1});
    end
    chk("sparse_busy_after", busy, 0);
    tick();

    // Zero mask, then another frame immediately
    send(dfull, '0);
    cap_data = dfull; cap_mask = 33'h20; cap_valid = 1'b1;
    @(negedge clk); #1;
    chk("zero_busy", busy, 0);
    chk("zero_out_valid", out_valid, 0);
    chk("zero_cap_ready", cap_ready, 1);
    @(posedge clk); #1;
    cap_valid = 1'b0;
    @(negedge clk); #1;
    chk("zero_next_valid", out_valid, 1);
    chk("zero_next_sel", out_sel, 5);
    chk("zero_next_data", out_data, 6);
    drain();
    tick();

    // Backpressure at sel 4 for 3 cycles
    logq.delete(); logcyc.delete();
    send(dfull, {DD{1'b1}});
    for (int n = 0; n < 50 && !(mq.size() != 0 && mq[0].sel == 4); n++) tick();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("bp_valid", out_valid, 1);
      chk("bp_sel", out_sel, 4);
      chk("bp_data", out_data, 5);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();
    chk_full_log("bp");
    tick();

    // Reset one cycle after the 5th beat was accepted
    logq.delete(); logcyc.delete();
    send(dfull, {DD{1'b1}});
    for (int n = 0; n < 50 && logq.size() < 5; n++) tick();
    chk("rst_mid_beats", logq.size(), 5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk); #1;
    chk("rstm_out_valid", out_valid, 0);
    chk("rstm_busy", busy, 0);
    chk("rstm_cap_ready", cap_ready, 1);
    chk("rstm_out_data", out_data, 0);
    chk("rstm_out_sel", out_sel, 0);
    chk("rstm_out_last", out_last, 0);
    tick();
    for (int i = 0; i < DD; i++) d[i*DW +: DW] = DW'(8'h40 + i);
    logq.delete(); logcyc.delete();
    send(d, 33'h280);
    drain();
    chk("rstm_count", logq.size(), 2);
    if (logq.size() == 2) begin
      chk("rstm_b0", logq[0], {6'd7, 8'h47, 1'b0});
      chk("rstm_b1", logq[1], {6'd9, 8'h49, 1'b1});
    end
    tick();

    // Two frames offered back-to-back: masks {1} and {3}
    d = '0; d[1*DW +: DW] = 8'h31; d[3*DW +: DW] = 8'h33;
    logq.delete(); logcyc.delete();
    send(d, 33'h2);
    send(d, 33'h8);
    drain();
    chk("b2b_count", logq.size(), 2);
    if (logq.size() == 2) begin
      chk("b2b_b0", logq[0], {6'd1, 8'h31, 1'b1});
      chk("b2b_b1", logq[1], {6'd3, 8'h33, 1'b1});
      chk("b2b_gap", logcyc[1] - logcyc[0], PIPE ? 1 : 2);
    end
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
